apb_uart_regfile: RTL and testbench

Parametrised APB3 slave register file for the UART core; the successor to the fixed 4-entry APB register block. Adds a proper setup/access handshake, a configurable number of wait states and a fixed register map. The map covers baud, TX/RX data, a status register with sticky W1C error bits, an interrupt-enable control register, and an interrupt output. Sits between the APB interconnect and the UART baud generator, TX FIFO and RX buffer.

---
 rtl/apb_uart_regfile.sv | 185 ++++++++++++++++++
 tb/tb_apb_uart_regfile.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_regfile.sv
// APB3 slave register file for the UART core: baud, TX/RX data, sticky status, irq enables.
// Define APB_UART_PSLVERR_EN to report unmapped/illegal accesses on pslverr.
module apb_uart_regfile #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 3,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] BAUD_RESET  = 16'h0003
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [2*DATA_W-1:0] baud_val,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_wr,
  input  logic                tx_rdy,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_rdy,
  output logic                rx_rd,
  input  logic                rx_ovf,
  output logic                irq
);

  localparam int                BAUD_W    = 2 * DATA_W;
  localparam logic [BAUD_W-1:0] BAUD_INIT = BAUD_W'(BAUD_RESET);
  localparam logic [3:0]        WS        = 4'(WAIT_STATES);

  localparam logic [ADDR_W-1:0] A_BAUD_LO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_BAUD_HI = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TXDATA  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RXDATA  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                latch, done, load;
  logic [ADDR_W-1:0]   addr_q, sel_addr;
  logic                write_q, sel_write;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   baud_lo, baud_hi;
  logic [2:0]          ctrl;
  logic                rx_ovf_st, tx_ovf_st, rx_pend;
  logic [DATA_W-1:0]   rd_value;
  logic                w1c_rx, w1c_tx, tx_drop;

  assign pready   = (state == ACCESS) && (cnt == WS);
  assign baud_val = {baud_hi, baud_lo};

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
          latch     = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (pready && penable) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else if (cnt != WS) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // prdata loads on the edge that raises pready; with no wait states that is the setup edge itself
  assign load      = (state_nxt == ACCESS) && (cnt_nxt == WS) && !pready;
  assign sel_addr  = latch ? paddr : addr_q;
  assign sel_write = latch ? pwrite : write_q;

  always_ff @(posedge pclk) begin
    if (latch) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
    end
  end

  always_comb begin
    rd_value = '0;
    if (!sel_write) begin
      case (sel_addr)
        A_BAUD_LO: rd_value = baud_lo;
        A_BAUD_HI: rd_value = baud_hi;
        A_RXDATA:  rd_value = rx_data;
        A_STATUS:  rd_value = DATA_W'({tx_ovf_st, rx_ovf_st, rx_rdy, tx_rdy});
        A_CTRL:    rd_value = DATA_W'(ctrl);
        default:   rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata  <= '0;
      rx_pend <= 1'b0;
    end else if (load) begin
      prdata  <= rd_value;
      rx_pend <= !sel_write && (sel_addr == A_RXDATA) && rx_rdy;
    end
  end

  assign w1c_rx  = done && write_q && (addr_q == A_STATUS) && wdata_q[2];
  assign w1c_tx  = done && write_q && (addr_q == A_STATUS) && wdata_q[3];
  assign tx_drop = done && write_q && (addr_q == A_TXDATA) && !tx_rdy;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      baud_lo   <= BAUD_INIT[DATA_W-1:0];
      baud_hi   <= BAUD_INIT[BAUD_W-1:DATA_W];
      ctrl      <= '0;
      tx_data   <= '0;
      tx_wr     <= 1'b0;
      rx_rd     <= 1'b0;
      rx_ovf_st <= 1'b0;
      tx_ovf_st <= 1'b0;
      irq       <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      rx_rd <= 1'b0;
      if (done) begin
        if (write_q) begin
          case (addr_q)
            A_BAUD_LO: baud_lo <= wdata_q;
            A_BAUD_HI: baud_hi <= wdata_q;
            A_TXDATA: begin
              if (tx_rdy) begin
                tx_data <= wdata_q;
                tx_wr   <= 1'b1;
              end
            end
            A_CTRL:    ctrl <= wdata_q[2:0];
            default:   ;
          endcase
        end else if (addr_q == A_RXDATA) begin
          rx_rd <= rx_pend;
        end
      end
      // a fresh overrun pulse outranks a simultaneous clear
      rx_ovf_st <= rx_ovf || (rx_ovf_st && !w1c_rx);
      tx_ovf_st <= tx_drop || (tx_ovf_st && !w1c_tx);
      irq <= (ctrl[0] && tx_rdy) || (ctrl[1] && rx_rdy) ||
             (ctrl[2] && (rx_ovf_st || tx_ovf_st));
    end
  end

`ifdef APB_UART_PSLVERR_EN
  // decoded from the latched request, so the response never depends on live APB inputs
  assign pslverr = pready && ((addr_q > A_CTRL) ||
                              (write_q && (addr_q == A_RXDATA)) ||
                              (!write_q && (addr_q == A_TXDATA)));
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_uart_regfile.sv
// Bench for apb_uart_regfile: two instances (0 and 3 wait states) on a shared, gated APB bus,
// checked against a register-map level reference model with directed and random accesses.
module tb_apb_uart_regfile;

  logic        pclk;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [2:0]  paddr;
  logic [7:0]  pwdata;
  logic        tx_rdy, rx_rdy, rx_ovf;
  logic [7:0]  rx_data;
  logic        dsel;

  logic        psel_a, psel_b;
  logic [7:0]  prdata_a, prdata_b, tx_data_a, tx_data_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic [15:0] baud_a, baud_b;
  logic        tx_wr_a, tx_wr_b, rx_rd_a, rx_rd_b, irq_a, irq_b;

  logic [7:0]  prdata_o, tx_data_o;
  logic        pready_o, pslverr_o, tx_wr_o, rx_rd_o, irq_o;
  logic [15:0] baud_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] m_lo[2], m_hi[2], m_txd[2];
  logic [2:0] m_ctrl[2];
  bit         m_srx[2], m_stx[2];

  assign psel_a = psel && !dsel;
  assign psel_b = psel && dsel;

  assign prdata_o  = dsel ? prdata_b  : prdata_a;
  assign pready_o  = dsel ? pready_b  : pready_a;
  assign pslverr_o = dsel ? pslverr_b : pslverr_a;
  assign tx_data_o = dsel ? tx_data_b : tx_data_a;
  assign tx_wr_o   = dsel ? tx_wr_b   : tx_wr_a;
  assign rx_rd_o   = dsel ? rx_rd_b   : rx_rd_a;
  assign irq_o     = dsel ? irq_b     : irq_a;
  assign baud_o    = dsel ? baud_b    : baud_a;

  apb_uart_regfile #(.DATA_W(8), .ADDR_W(3), .WAIT_STATES(0), .BAUD_RESET(16'h0003)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
    .baud_val(baud_a), .tx_data(tx_data_a), .tx_wr(tx_wr_a), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rd(rx_rd_a), .rx_ovf(rx_ovf), .irq(irq_a)
  );

  apb_uart_regfile #(.DATA_W(8), .ADDR_W(3), .WAIT_STATES(3), .BAUD_RESET(16'h0003)) u_ws3 (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
    .baud_val(baud_b), .tx_data(tx_data_b), .tx_wr(tx_wr_b), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rd(rx_rd_b), .rx_ovf(rx_ovf), .irq(irq_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lo[i] = 8'h03; m_hi[i] = 8'h00; m_txd[i] = 8'h00;
      m_ctrl[i] = 3'b000; m_srx[i] = 1'b0; m_stx[i] = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_read(input int d, input int a);
    case (a)
      0: return m_lo[d];
      1: return m_hi[d];
      3: return rx_data;
      4: return {4'b0, m_stx[d], m_srx[d], rx_rdy, tx_rdy};
      5: return {5'b0, m_ctrl[d]};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_irq(input int d);
    return (m_ctrl[d][0] & tx_rdy) | (m_ctrl[d][1] & rx_rdy) | (m_ctrl[d][2] & (m_srx[d] | m_stx[d]));
  endfunction

  function automatic logic model_err(input bit w, input int a);
`ifdef APB_UART_PSLVERR_EN
    return (a >= 6) || (w && a == 3) || (!w && a == 2);
`else
    return 1'b0;
`endif
  endfunction

  // One APB transfer; caller is just after a rising edge, returns just after the completion edge.
  task automatic xfer(input int d, input bit w, input int a, input logic [7:0] wd, input bit ovf_commit,
                      output logic [7:0] rd, output int ncyc, output logic err, output bit ok);
    dsel = (d != 0); psel = 1'b1; penable = 1'b0; pwrite = w; paddr = 3'(a); pwdata = wd;
    rd = 8'hxx; err = 1'bx; ok = 1'b0; ncyc = 1;
    @(posedge pclk); #1;
    penable = 1'b1;
    while (!ok && ncyc <= 20) begin
      if (pready_o === 1'b1) begin
        ok = 1'b1; rd = prdata_o; err = pslverr_o;
      end else begin
        @(posedge pclk); #1;
        ncyc++;
      end
    end
    if (ok) rx_ovf = ovf_commit;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; rx_ovf = 1'b0;
  endtask

  task automatic op(input int d, input bit w, input int a, input logic [7:0] wd, input bit ovf_commit);
    logic [7:0] exp_rd, rd;
    logic       err, exp_txwr, exp_rxrd;
    int         ncyc;
    bit         ok;
    exp_rd   = model_read(d, a);
    exp_rxrd = !w && a == 3 && rx_rdy;
    exp_txwr = w && a == 2 && tx_rdy;
    xfer(d, w, a, wd, ovf_commit, rd, ncyc, err, ok);
    chk("pready_seen", 32'(ok), 32'd1);
    chk("access_cycles", 32'(ncyc), (d != 0) ? 32'd4 : 32'd1);
    chk("pslverr", 32'(err), 32'(model_err(w, a)));
    if (!w) chk($sformatf("prdata d%0d a%0d", d, a), 32'(rd), 32'(exp_rd));
    if (w) begin
      case (a)
        0: m_lo[d] = wd;
        1: m_hi[d] = wd;
        2: if (tx_rdy) m_txd[d] = wd; else m_stx[d] = 1'b1;
        4: begin
          if (wd[2]) m_srx[d] = 1'b0;
          if (wd[3]) m_stx[d] = 1'b0;
        end
        5: m_ctrl[d] = wd[2:0];
        default: ;
      endcase
    end
    if (ovf_commit) begin m_srx[0] = 1'b1; m_srx[1] = 1'b1; end
    chk("tx_wr_pulse", 32'(tx_wr_o), 32'(exp_txwr));
    chk("rx_rd_pulse", 32'(rx_rd_o), 32'(exp_rxrd));
    chk("tx_data", 32'(tx_data_o), 32'(m_txd[d]));
    chk("baud_val", 32'(baud_o), 32'({m_hi[d], m_lo[d]}));
    @(posedge pclk); #1;
    chk("tx_wr_end", 32'(tx_wr_o), 32'd0);
    chk("rx_rd_end", 32'(rx_rd_o), 32'd0);
    chk("irq", 32'(irq_o), 32'(model_irq(d)));
  endtask

  task automatic pulse_ovf();
    rx_ovf = 1'b1;
    @(posedge pclk); #1;
    rx_ovf = 1'b0;
    m_srx[0] = 1'b1; m_srx[1] = 1'b1;
  endtask

  initial begin
    logic [7:0] rd0, rd1;
    logic       e0, e1;
    int         n0, n1;
    bit         ok0, ok1;

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_rdy = 1'b0; rx_rdy = 1'b0; rx_ovf = 1'b0; rx_data = '0; dsel = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready_a", 32'(pready_a), 32'd0);
    chk("rst_pready_b", 32'(pready_b), 32'd0);
    chk("rst_prdata_a", 32'(prdata_a), 32'd0);
    chk("rst_irq_b", 32'(irq_b), 32'd0);
    chk("rst_baud_b", 32'(baud_b), 32'h0003);
    chk("rst_tx_data_a", 32'(tx_data_a), 32'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // back-to-back BAUD reads on the zero-wait instance
    xfer(0, 1'b0, 0, 8'h00, 1'b0, rd0, n0, e0, ok0);
    xfer(0, 1'b0, 1, 8'h00, 1'b0, rd1, n1, e1, ok1);
    chk("b2b_ok", 32'({ok0, ok1}), 32'b11);
    chk("baud_lo_read", 32'(rd0), 32'h03);
    chk("baud_hi_read", 32'(rd1), 32'h00);
    chk("ws0_cycles", 32'(n0 + n1), 32'd2);

    // TX write with space, then with the FIFO full
    tx_rdy = 1'b1;
    op(1, 1'b1, 2, 8'hA5, 1'b0);
    tx_rdy = 1'b0;
    op(1, 1'b1, 2, 8'h5A, 1'b0);
    op(1, 1'b0, 4, 8'h00, 1'b0);
    op(1, 1'b1, 4, 8'h08, 1'b0);
    op(1, 1'b0, 4, 8'h00, 1'b0);

    // RX path and irq enable
    rx_rdy = 1'b1; rx_data = 8'h3C;
    op(0, 1'b1, 5, 8'h02, 1'b0);
    op(0, 1'b0, 3, 8'h00, 1'b0);
    op(0, 1'b0, 5, 8'h00, 1'b0);

    // overrun pulse coincident with its W1C clear
    pulse_ovf();
    op(1, 1'b1, 5, 8'h04, 1'b0);
    op(1, 1'b1, 4, 8'h04, 1'b1);
    op(1, 1'b0, 4, 8'h00, 1'b0);

    // unmapped and illegal accesses
    op(0, 1'b0, 6, 8'h00, 1'b0);
    op(1, 1'b0, 7, 8'h00, 1'b0);
    op(0, 1'b1, 3, 8'h77, 1'b0);
    op(1, 1'b0, 2, 8'h00, 1'b0);

    // reset in the middle of a waited TX write
    tx_rdy = 1'b1;
    dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'hEE;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    chk("abort_pready", 32'(pready_b), 32'd0);
    chk("abort_tx_wr", 32'(tx_wr_b), 32'd0);
    chk("abort_rx_rd", 32'(rx_rd_b), 32'd0);
    psel = 1'b0; penable = 1'b0;
    model_reset();
    @(posedge pclk); #1;
    presetn = 1'b1;
    repeat (4) begin
      @(posedge pclk); #1;
      chk("post_abort_tx_wr", 32'(tx_wr_b), 32'd0);
    end
    chk("post_abort_tx_data", 32'(tx_data_b), 32'd0);
    chk("post_abort_baud", 32'(baud_b), 32'h0003);

    // randomized accesses against the register-map model
    for (int i = 0; i < 160; i++) begin
      tx_rdy  = 1'($urandom_range(0, 1));
      rx_rdy  = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      if ($urandom_range(0, 7) == 0) pulse_ovf();
      op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
         8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
